// File: rtl/dcache_lsu.sv
// Load/store unit driving the 16-bit data cache port; byte stores run as read-modify-write.
// Optional build macro LSU_RANGE_CHECK_EN rejects word addresses beyond DEPTH.
module dcache_lsu #(
  parameter int DEPTH = 256,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  output logic          core_ready,
  input  logic          core_we,
  input  logic          core_byte,
  input  logic          core_sext,
  input  logic [15:0]   core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_r_en,
  output logic          mem_w_en,
  output logic [15:0]   mem_addr,
  output logic [DW-1:0] mem_w_data,
  input  logic [DW-1:0] mem_r_data
);

  if (DW != 16 || DEPTH < 1 || DEPTH > 32768) begin : g_bad_cfg
    $error("dcache_lsu: unsupported DW/DEPTH");
  end

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RMW_RD, RMW_CAP, RMW_WR} state_e;

  state_e        state_q, state_d;
  logic          we_q, byte_q, sext_q;
  logic [15:0]   addr_q;
  logic [DW-1:0] wdata_q, merged_q;
  logic          rsp_valid_q, rsp_err_q;
  logic [DW-1:0] rsp_rdata_q;
  logic          accept, reject;

  function automatic logic [15:0] byte_load(input logic [15:0] word, input logic hi,
                                            input logic sext);
    logic [7:0] b;
    b = hi ? word[15:8] : word[7:0];
    return {(sext && b[7]) ? 8'hFF : 8'h00, b};
  endfunction

  function automatic logic [15:0] byte_merge(input logic [15:0] word, input logic [7:0] b,
                                             input logic hi);
    return hi ? {b, word[7:0]} : {word[15:8], b};
  endfunction

  assign accept = core_req && (state_q == IDLE);

  always_comb begin
    reject = core_addr[0] && !core_byte;
`ifdef LSU_RANGE_CHECK_EN
    if ({1'b0, core_addr[15:1]} >= 16'(DEPTH)) reject = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && !reject) begin
          if (!core_we)       state_d = RD;
          else if (core_byte) state_d = RMW_RD;
          else                state_d = WR;
        end
      end
      RD:      state_d = CAP;
      CAP:     state_d = IDLE;
      WR:      state_d = IDLE;
      RMW_RD:  state_d = RMW_CAP;
      RMW_CAP: state_d = RMW_WR;
      RMW_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latches and registered response; rejected requests answer one cycle after acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      sext_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      merged_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      if (accept) begin
        we_q    <= core_we;
        byte_q  <= core_byte;
        sext_q  <= core_sext;
        addr_q  <= core_addr;
        wdata_q <= core_wdata;
        if (reject) begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
        end
      end
      case (state_q)
        CAP: begin
          rsp_rdata_q <= byte_q ? byte_load(mem_r_data, addr_q[0], sext_q) : mem_r_data;
          rsp_valid_q <= 1'b1;
        end
        RMW_CAP: merged_q <= byte_merge(mem_r_data, wdata_q[7:0], addr_q[0]);
        WR, RMW_WR: rsp_valid_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // Cache strobes decode from the state register only, so reset drops them asynchronously.
  assign core_ready = (state_q == IDLE);
  assign mem_r_en   = (state_q == RD) || (state_q == RMW_RD);
  assign mem_w_en   = (state_q == WR) || (state_q == RMW_WR);
  assign mem_addr   = {1'b0, addr_q[15:1]};
  assign mem_w_data = (state_q == WR)     ? wdata_q  :
                      (state_q == RMW_WR) ? merged_q : '0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  logic unused_we;
  assign unused_we = we_q;

endmodule
